wb_select_stage: RTL and testbench
==================================

# wb_select_stage

Parametrised writeback-select stage for the RV32 core, sitting between the data-memory interface and the register file. It generalises the 4-way mem-to-reg result mux with:
- a registered output and a valid/ready handshake;
- load byte/half extraction with sign or zero extension;
- a wait state for variable-latency memory reads, with a timeout.

It delivers one register-file write per accepted instruction.

## Interface
- XLEN, 32: datapath width. Only 32 is supported; load extraction assumes 4-byte words.
- PC_W, 10: width of the PC+4 input. Zero-extended to XLEN.
- TIMEOUT, 16: maximum cycles spent waiting for mem_rvalid. Must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction presented for writeback.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- mem_to_reg  in  2  source select: 0 ALU, 1 memory load, 2 PC+4, 3 immediate.
- alu_result  in  XLEN  ALU result.
- imm  in  XLEN  U-type immediate (LUI).
- pc_4  in  PC_W  PC+4 of the instruction.
- funct3  in  3  load type, used only when mem_to_reg==1.
- byte_off  in  2  address[1:0] of the load.
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- mem_rdata  in  XLEN  raw aligned word from data memory.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- wb_we  out  1  register-file write enable, registered.
- wb_rd  out  5  write address, registered.
- wb_data  out  XLEN  write data, registered.
- misalign_err  out  1  one-cycle pulse: misaligned or illegal load.
- timeout_err  out  1  one-cycle pulse: memory did not respond.

## Operation
- States: IDLE and WAIT_MEM.
- Accept occurs on a clock edge where in_valid && in_ready.

Accept with mem_to_reg ∈ {0,2,3}:
- Stay in IDLE.
- At that edge: wb_data ← alu_result, zext(pc_4), or imm respectively.
- wb_rd ← rd.
- wb_we ← reg_write && rd!=0.

Accept with mem_to_reg==1:
- Latch funct3, byte_off, rd and reg_write.
- Check legality:
  - illegal funct3 (anything other than 000, 001, 010, 100, 101);
  - LH or LHU with byte_off[0]=1;
  - LW with byte_off!=0.
- If illegal: misalign_err pulses the next cycle, wb_we ← 0, remain IDLE.
- Otherwise: go to WAIT_MEM, clear the wait counter.

WAIT_MEM:
- mem_rvalid is sampled only in this state, never in the accept cycle.
- On mem_rvalid: extract the result from mem_rdata.
  - LB/LBU: byte byte_off, sign-/zero-extended.
  - LH/LHU: half byte_off[1], sign-/zero-extended.
  - LW: whole word.
- On that edge: write the result with the wb_we rule above, then return to IDLE.
- Wait counter increments each WAIT_MEM cycle without mem_rvalid.
- Timeout: on the TIMEOUT-th such cycle, timeout_err pulses, wb_we ← 0, return to IDLE.
- mem_rvalid on that same cycle wins: normal writeback, no error.

Output rules:
- wb_we, misalign_err and timeout_err are single-cycle pulses. They are 0 in every cycle with no completing instruction.
- wb_data and wb_rd hold their last value when wb_we=0.

## Timing
- Reset values: state IDLE, wb_we 0, wb_rd 0, wb_data 0, misalign_err 0, timeout_err 0, counter 0. Hence in_ready=1 during and after reset.
- Non-load latency: 1 cycle, accept edge to wb_we high. Throughput is 1 per cycle.
- Load latency: result is written at the edge where mem_rvalid is seen in WAIT_MEM. Minimum 2 cycles after accept.
- in_ready is low for every WAIT_MEM cycle. Back-to-back accept is possible in the cycle after a load completes.
- Reset asserted in WAIT_MEM aborts the load. No write and no error pulse occur.
- The counter is $clog2(TIMEOUT+1) bits wide and never wraps.

## Structure
- Shared package core_pkg holds:
  - WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_PC4=2, WB_SRC_IMM=3;
  - load funct3 constants LB, LH, LW, LBU, LHU;
  - the state enum.
- One sub-module, load_extend: purely combinational. Takes funct3, byte_off and mem_rdata and produces the extended data and an illegal flag. The top holds the FSM, counter and output registers.

## Test plan
- Reset, then present mem_to_reg=0, alu_result=15, rd=5, reg_write=1 → next cycle wb_we=1, wb_rd=5, wb_data=15. Repeat with mem_to_reg=2, pc_4=4 → wb_data=4. Repeat with mem_to_reg=3, imm=0x12345000 → wb_data=0x12345000.
- Load LB, byte_off=3, mem_rdata=0x80FF_0014, mem_rvalid 2 cycles after accept → in_ready low for 2 cycles, then wb_data=0xFFFF_FF80. Same stimulus with LBU → 0x0000_0080.
- LH with byte_off=1 → misalign_err pulse for one cycle, wb_we=0, in_ready stays 1. LW with byte_off=2 → same response.
- Load with rd=0, mem_rdata=20 → completes with wb_we=0.
- Load with TIMEOUT=4 and no mem_rvalid → timeout_err pulses after 4 WAIT_MEM cycles, returns to IDLE, no write. Repeat with mem_rvalid arriving on the 4th cycle → normal write, no error.
- Assert rst mid-WAIT_MEM → all outputs 0 immediately. A later late mem_rvalid causes no write.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: writeback source selects, load funct3 codes, writeback FSM states.
package core_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC4 = 2'd2;
    localparam logic [1:0] WB_SRC_IMM = 2'd3;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load extraction: selects byte/half/word from an aligned word and extends it.
// Also flags illegal funct3 codes and misaligned halfword/word accesses; zero latency, no handshake.
module load_extend
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    assign shifted = mem_rdata >> {byte_off, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            LH: begin
                data    = {{(XLEN-16){half_v[15]}}, half_v};
                illegal = byte_off[0];
            end
            LHU: begin
                data    = {{(XLEN-16){1'b0}}, half_v};
                illegal = byte_off[0];
            end
            LW: begin
                data    = mem_rdata;
                illegal = |byte_off;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select: registers ALU/PC+4/imm results in 1 cycle, loads complete on the edge mem_rvalid is seen.
// in_ready drops while a load waits for memory; a silent memory times out after TIMEOUT wait cycles.
module wb_select_stage
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_W    = 10,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      mem_to_reg,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] imm,
    input  logic [PC_W-1:0] pc_4,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_err,
    output logic            timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]      lat_funct3;
    logic [1:0]      lat_off;
    logic [4:0]      lat_rd;
    logic            lat_we;

    logic            accept;
    logic            nonload_we;
    logic            load_we;
    logic [XLEN-1:0] nonload_data;
    logic [2:0]      ext_funct3;
    logic [1:0]      ext_off;
    logic [XLEN-1:0] ext_data;
    logic            ext_illegal;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign nonload_we = reg_write && (rd != 5'd0);
    assign load_we    = lat_we && (lat_rd != 5'd0);

    // One extractor serves both the legality check at accept and the extraction in WAIT_MEM.
    assign ext_funct3 = (state == WAIT_MEM) ? lat_funct3 : funct3;
    assign ext_off    = (state == WAIT_MEM) ? lat_off    : byte_off;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3    (ext_funct3),
        .byte_off  (ext_off),
        .mem_rdata (mem_rdata),
        .data      (ext_data),
        .illegal   (ext_illegal)
    );

    always_comb begin
        nonload_data = alu_result;
        case (mem_to_reg)
            WB_SRC_PC4: nonload_data = {{(XLEN-PC_W){1'b0}}, pc_4};
            WB_SRC_IMM: nonload_data = imm;
            default:    nonload_data = alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            lat_funct3   <= 3'b000;
            lat_off      <= 2'b00;
            lat_rd       <= 5'd0;
            lat_we       <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wb_we        <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (mem_to_reg == WB_SRC_MEM) begin
                            lat_funct3 <= funct3;
                            lat_off    <= byte_off;
                            lat_rd     <= rd;
                            lat_we     <= reg_write;
                            if (ext_illegal) begin
                                misalign_err <= 1'b1;
                            end else begin
                                state    <= WAIT_MEM;
                                wait_cnt <= '0;
                            end
                        end else begin
                            wb_we <= nonload_we;
                            if (nonload_we) begin
                                wb_rd   <= rd;
                                wb_data <= nonload_data;
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response on the final wait cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        wb_we <= load_we;
                        if (load_we) begin
                            wb_rd   <= lat_rd;
                            wb_data <= ext_data;
                        end
                        state <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Randomized bench for wb_select_stage against a behavioural load/writeback model.
module tb_wb_select_stage;

    localparam int XLEN = 32;
    localparam int PC_W = 10;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      mem_to_reg = 2'd0;
    logic [XLEN-1:0] alu_result = '0;
    logic [XLEN-1:0] imm = '0;
    logic [PC_W-1:0] pc_4 = '0;
    logic [2:0]      funct3 = 3'd0;
    logic [1:0]      byte_off = 2'd0;
    logic [4:0]      rd = 5'd0;
    logic            reg_write = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            mem_rvalid = 1'b0;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            misalign_err;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;

    // Architectural view of the last committed register-file write.
    logic [4:0]  exp_rd = 5'd0;
    logic [31:0] exp_data = 32'd0;

    wb_select_stage #(.XLEN(XLEN), .PC_W(PC_W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_to_reg   (mem_to_reg),
        .alu_result   (alu_result),
        .imm          (imm),
        .pc_4         (pc_4),
        .funct3       (funct3),
        .byte_off     (byte_off),
        .rd           (rd),
        .reg_write    (reg_write),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Returns {illegal, value} computed arithmetically from the RV32 load rules.
    function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(off))) % 256;
        h = (w >> (16 * int'(off[1]))) % 65536;
        case (f3)
            3'b000:  return {1'b0, (b >= 128) ? b - 32'd256 : b};
            3'b100:  return {1'b0, b};
            3'b001:  return {(off % 2) != 0, (h >= 32768) ? h - 32'd65536 : h};
            3'b101:  return {(off % 2) != 0, h};
            3'b010:  return {off != 0, w};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Drives one non-load accept and checks the registered result one edge later.
    task automatic run_nonload(input logic [1:0] src, input logic [31:0] alu, input logic [9:0] pc,
                               input logic [31:0] im, input logic [4:0] r, input logic rw,
                               input string name);
        logic        we;
        logic [31:0] res;
        in_valid   = 1'b1;
        mem_to_reg = src;
        alu_result = alu;
        pc_4       = pc;
        imm        = im;
        rd         = r;
        reg_write  = rw;
        funct3     = 3'($urandom);
        byte_off   = 2'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        @(posedge clk); #1;
        res = (src == 2'd0) ? alu : (src == 2'd2) ? 32'(pc) : im;
        we  = rw && (r != 0);
        if (we) begin
            exp_rd   = r;
            exp_data = res;
        end
        checks++;
        if ({wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready} !==
            {we, exp_rd, exp_data, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s: we/rd/data/mis/to/rdy got %b %0d %h %b %b %b expected %b %0d %h 0 0 1",
                     name, wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready,
                     we, exp_rd, exp_data);
        end
    endtask

    // Drives one load accept, answers after 'delay' wait cycles (or never if delay > TO).
    task automatic run_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w,
                            input logic [4:0] r, input logic rw, input int delay, input string name);
        logic [32:0] m;
        logic        we;
        int          n;
        m = model_load(f3, off, w);
        in_valid   = 1'b1;
        mem_to_reg = 2'd1;
        funct3     = f3;
        byte_off   = off;
        rd         = r;
        reg_write  = rw;
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        funct3     = 3'($urandom);
        byte_off   = 2'($urandom);
        rd         = 5'($urandom);
        reg_write  = 1'($urandom);
        if (m[32]) begin
            checks++;
            if ({misalign_err, timeout_err, wb_we, in_ready, wb_rd, wb_data} !==
                {1'b1, 1'b0, 1'b0, 1'b1, exp_rd, exp_data}) begin
                errors++;
                $display("FAIL %s_illegal: mis/to/we/rdy/rd/data got %b %b %b %b %0d %h expected 1 0 0 1 %0d %h",
                         name, misalign_err, timeout_err, wb_we, in_ready, wb_rd, wb_data,
                         exp_rd, exp_data);
            end
        end else begin
            n = (delay > TO) ? TO : delay;
            for (int k = 1; k <= n; k++) begin
                checks++;
                if ({in_ready, wb_we, misalign_err, timeout_err} !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s_wait%0d: rdy/we/mis/to got %b%b%b%b expected 0000",
                             name, k, in_ready, wb_we, misalign_err, timeout_err);
                end
                mem_rvalid = (k == delay);
                mem_rdata  = (k == delay) ? w : $urandom;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
            if (delay <= TO) begin
                we = rw && (r != 0);
                if (we) begin
                    exp_rd   = r;
                    exp_data = m[31:0];
                end
                checks++;
                if ({wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready} !==
                    {we, exp_rd, exp_data, 1'b0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL %s_done: we/rd/data/mis/to/rdy got %b %0d %h %b %b %b expected %b %0d %h 0 0 1",
                             name, wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready,
                             we, exp_rd, exp_data);
                end
            end else begin
                checks++;
                if ({timeout_err, misalign_err, wb_we, in_ready, wb_rd, wb_data} !==
                    {1'b1, 1'b0, 1'b0, 1'b1, exp_rd, exp_data}) begin
                    errors++;
                    $display("FAIL %s_timeout: to/mis/we/rdy/rd/data got %b %b %b %b %0d %h expected 1 0 0 1 %0d %h",
                             name, timeout_err, misalign_err, wb_we, in_ready, wb_rd, wb_data,
                             exp_rd, exp_data);
                end
            end
        end
        // Idle cycle: every pulse must have dropped.
        @(posedge clk); #1;
        checks++;
        if ({wb_we, misalign_err, timeout_err, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL %s_pulse: we/mis/to/rdy got %b%b%b%b expected 0001",
                     name, wb_we, misalign_err, timeout_err, in_ready);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready} !== {1'b0, 5'd0, 32'd0, 3'b001}) begin
            errors++;
            $display("FAIL reset: we/rd/data/mis/to/rdy got %b %0d %h %b %b %b expected 0 0 0 0 0 1",
                     wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready} !== {1'b0, 5'd0, 32'd0, 3'b001}) begin
            errors++;
            $display("FAIL post_reset: we/rd/data/mis/to/rdy got %b %0d %h %b %b %b expected 0 0 0 0 0 1",
                     wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready);
        end
    endtask

    task automatic test_nonload;
        run_nonload(2'd0, 32'd15, 10'd0, 32'd0, 5'd5, 1'b1, "alu");
        run_nonload(2'd2, 32'd0, 10'd4, 32'd0, 5'd5, 1'b1, "pc4");
        run_nonload(2'd3, 32'd0, 10'd0, 32'h1234_5000, 5'd5, 1'b1, "imm");
        run_nonload(2'd0, 32'hDEAD_BEEF, 10'd0, 32'd0, 5'd0, 1'b1, "alu_rd0");
        run_nonload(2'd3, 32'd0, 10'd0, 32'hCAFE_0000, 5'd9, 1'b0, "imm_nowrite");
        run_nonload(2'd2, 32'd0, 10'h3FF, 32'd0, 5'd31, 1'b1, "pc4_max");
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [1:0] src;
        for (int i = 0; i < 24; i++) begin
            src = 2'($urandom_range(0, 2));
            if (src == 2'd1) src = 2'd3;
            run_nonload(src, $urandom, 10'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0),
                        "b2b");
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads_directed;
        run_load(3'b000, 2'd3, 32'h80FF_0014, 5'd7, 1'b1, 2, "lb_off3");
        run_load(3'b100, 2'd3, 32'h80FF_0014, 5'd7, 1'b1, 2, "lbu_off3");
        run_load(3'b001, 2'd2, 32'h80FF_0014, 5'd8, 1'b1, 1, "lh_hi");
        run_load(3'b101, 2'd0, 32'h1234_F00D, 5'd8, 1'b1, 1, "lhu_lo");
        run_load(3'b010, 2'd0, 32'hA5A5_0001, 5'd3, 1'b1, 3, "lw");
        run_load(3'b001, 2'd1, 32'h0, 5'd4, 1'b1, 1, "lh_misalign");
        run_load(3'b010, 2'd2, 32'h0, 5'd4, 1'b1, 1, "lw_misalign");
        run_load(3'b011, 2'd0, 32'h0, 5'd4, 1'b1, 1, "f3_illegal");
        run_load(3'b010, 2'd0, 32'd20, 5'd0, 1'b1, 1, "load_rd0");
        run_load(3'b010, 2'd0, 32'h1111_2222, 5'd6, 1'b1, TO + 1, "timeout");
        run_load(3'b010, 2'd0, 32'h3333_4444, 5'd6, 1'b1, TO, "rvalid_last");
    endtask

    task automatic test_loads_random;
        for (int i = 0; i < 40; i++) begin
            run_load(3'($urandom), 2'($urandom), $urandom, 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 3) != 0), $urandom_range(1, TO + 2), "rand_load");
        end
    endtask

    task automatic test_reset_mid_wait;
        in_valid   = 1'b1;
        mem_to_reg = 2'd1;
        funct3     = 3'b010;
        byte_off   = 2'd0;
        rd         = 5'd12;
        reg_write  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait_pre: in_ready got %b expected 0", in_ready);
        end
        #2 rst = 1'b1;
        #1;
        exp_rd   = 5'd0;
        exp_data = 32'd0;
        checks++;
        if ({wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready} !== {1'b0, 5'd0, 32'd0, 3'b001}) begin
            errors++;
            $display("FAIL rst_mid_wait: we/rd/data/mis/to/rdy got %b %0d %h %b %b %b expected 0 0 0 0 0 1",
                     wb_we, wb_rd, wb_data, misalign_err, timeout_err, in_ready);
        end
        @(posedge clk); #1;
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({wb_we, wb_rd, wb_data, timeout_err, in_ready} !== {1'b0, 5'd0, 32'd0, 2'b01}) begin
                errors++;
                $display("FAIL late_rvalid%0d: we/rd/data/to/rdy got %b %0d %h %b %b expected 0 0 0 0 1",
                         k, wb_we, wb_rd, wb_data, timeout_err, in_ready);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_back_to_back();
        test_loads_directed();
        test_loads_random();
        test_reset_mid_wait();
        run_nonload(2'd0, 32'd99, 10'd0, 32'd0, 5'd1, 1'b1, "after_reset");
        in_valid = 1'b0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
